// File: rtl/t05_htree_decode.sv
// -----------------------------------------------------------------------------
// t05_htree_decode
//
// Huffman tree walker for the decompression path. Reads tree nodes from SRAM,
// consumes the encoded bitstream one bit at a time, walks from the root to a
// leaf and emits one 8-bit character per leaf reached. The root node is cached
// after its first read, so each new character restarts from the cached copy
// without another SRAM access.
//
// Node layout (NODE_W = 71): {index[70:64], child0[63:55], child1[54:46],
// sum[45:0]}. Child encoding: 9'h180 = null, bit8=1 = sum node (index in
// [6:0]), bit8=0 = leaf (character in [7:0]).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                level enable; low aborts and returns to IDLE
//   root_index        SRAM index of the root node (latched on start)
//   num_chars         number of characters to decode (latched on start)
//   bit_in/bit_valid  encoded bit input, transferred when bit_ready is high
//   bit_ready         decoder accepts a bit this cycle
//   rd_req/rd_addr    node read request, held until rd_done
//   rd_data/rd_done   node read data, valid in the rd_done pulse cycle
//   char_out          decoded character
//   char_valid        one-cycle strobe qualifying char_out
//   char_count        characters emitted since start
//   op_fin            status: 0000 busy/idle, 0011 done, 1000 error
//
// All outputs come from registers or from a decode of the state register, so
// there is no combinational path from rd_data or bit_in to any output.
// -----------------------------------------------------------------------------
module t05_htree_decode #(
  parameter int NODE_W = 71,
  parameter int IDX_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [IDX_W-1:0]  root_index,
  input  logic [CNT_W-1:0]  num_chars,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              rd_req,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [NODE_W-1:0] rd_data,
  input  logic              rd_done,
  output logic [7:0]        char_out,
  output logic              char_valid,
  output logic [CNT_W-1:0]  char_count,
  output logic [3:0]        op_fin
);

  localparam int CHILD_W = 9;
  localparam int DEPTH_W = 7;
  localparam int IDX_MSB = NODE_W - 1;
  localparam int C0_MSB  = NODE_W - IDX_W - 1;
  localparam int C1_MSB  = C0_MSB - CHILD_W;
  localparam int SUM_MSB = C1_MSB - CHILD_W;

  localparam logic [CHILD_W-1:0] CHILD_NULL = 9'h180;
  localparam logic [3:0]         FIN_BUSY   = 4'b0000;
  localparam logic [3:0]         FIN_DONE   = 4'b0011;
  localparam logic [3:0]         FIN_ERR    = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BIT,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t next_state;

  // Latched job parameters
  logic [IDX_W-1:0]   root_idx_r;
  logic [CNT_W-1:0]   num_r;

  // Walk state
  logic [IDX_W-1:0]   cur_addr;
  logic [CHILD_W-1:0] node_c0;
  logic [CHILD_W-1:0] node_c1;
  logic [CHILD_W-1:0] root_c0;
  logic [CHILD_W-1:0] root_c1;
  logic               root_valid;
  logic [7:0]         char_reg;
  logic [CNT_W-1:0]   cnt_r;
  logic [DEPTH_W-1:0] depth;

  // Decoded conditions
  logic [CHILD_W-1:0] sel_child;
  logic               child_null;
  logic               child_sum;
  logic               fetch_idx_ok;
  logic               depth_max;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_char;

  // The sum field of a node is not needed for decoding.
  logic unused_sum;
  assign unused_sum = ^rd_data[SUM_MSB:0];

  always_comb begin
    sel_child    = bit_in ? node_c1 : node_c0;
    child_null   = (sel_child == CHILD_NULL);
    child_sum    = sel_child[CHILD_W-1] && !child_null;
    fetch_idx_ok = (rd_data[IDX_MSB -: IDX_W] == cur_addr);
    depth_max    = &depth;
    cnt_inc      = cnt_r + CNT_W'(1);
    last_char    = (cnt_inc == num_r);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (en) begin
          next_state = (num_chars == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_done) begin
          next_state = fetch_idx_ok ? S_BIT : S_ERR;
        end
      end
      S_BIT: begin
        if (bit_valid) begin
          // Depth guard takes priority so a cyclic tree always terminates.
          if (depth_max || child_null) begin
            next_state = S_ERR;
          end else if (child_sum) begin
            next_state = S_FETCH;
          end else begin
            next_state = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (last_char) begin
          next_state = S_DONE;
        end else if (!root_valid) begin
          next_state = S_ERR;
        end else begin
          next_state = S_BIT;
        end
      end
      S_DONE:  next_state = S_DONE;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_ERR;
    endcase
    if (!en) begin
      next_state = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_req     = (state == S_FETCH);
    bit_ready  = (state == S_BIT);
    char_valid = (state == S_EMIT);
    case (state)
      S_DONE:  op_fin = FIN_DONE;
      S_ERR:   op_fin = FIN_ERR;
      default: op_fin = FIN_BUSY;
    endcase
  end

  assign rd_addr    = cur_addr;
  assign char_out   = char_reg;
  assign char_count = cnt_r;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_idx_r <= '0;
      num_r      <= '0;
      cur_addr   <= '0;
      node_c0    <= '0;
      node_c1    <= '0;
      root_c0    <= '0;
      root_c1    <= '0;
      root_valid <= 1'b0;
      char_reg   <= '0;
      cnt_r      <= '0;
      depth      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            root_idx_r <= root_index;
            num_r      <= num_chars;
            cur_addr   <= root_index;
            cnt_r      <= '0;
            root_valid <= 1'b0;
            depth      <= '0;
          end
        end
        S_FETCH: begin
          if (en && rd_done && fetch_idx_ok) begin
            node_c0 <= rd_data[C0_MSB -: CHILD_W];
            node_c1 <= rd_data[C1_MSB -: CHILD_W];
            if (cur_addr == root_idx_r) begin
              root_c0    <= rd_data[C0_MSB -: CHILD_W];
              root_c1    <= rd_data[C1_MSB -: CHILD_W];
              root_valid <= 1'b1;
            end
          end
        end
        S_BIT: begin
          if (en && bit_valid && !depth_max) begin
            depth <= depth + DEPTH_W'(1);
            if (child_sum) begin
              cur_addr <= sel_child[IDX_W-1:0];
            end else if (!child_null) begin
              char_reg <= sel_child[7:0];
            end
          end
        end
        S_EMIT: begin
          // char_valid is already high this cycle, so the count advances
          // even if en drops at the same time.
          cnt_r   <= cnt_inc;
          depth   <= '0;
          node_c0 <= root_c0;
          node_c1 <= root_c1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
